// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 fetch/execute sequencer: opcodes, FSM states,
// operand and destination selects.
package td4_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD_A  = 4'b0000;
    localparam logic [OP_W-1:0] OP_MOV_AB = 4'b0001;
    localparam logic [OP_W-1:0] OP_IN_A   = 4'b0010;
    localparam logic [OP_W-1:0] OP_MOV_AI = 4'b0011;
    localparam logic [OP_W-1:0] OP_MOV_BA = 4'b0100;
    localparam logic [OP_W-1:0] OP_ADD_B  = 4'b0101;
    localparam logic [OP_W-1:0] OP_IN_B   = 4'b0110;
    localparam logic [OP_W-1:0] OP_MOV_BI = 4'b0111;
    localparam logic [OP_W-1:0] OP_OUT_B  = 4'b1001;
    localparam logic [OP_W-1:0] OP_OUT_I  = 4'b1011;
    localparam logic [OP_W-1:0] OP_JNC    = 4'b1110;
    localparam logic [OP_W-1:0] OP_JMP    = 4'b1111;

    typedef enum logic {
        ST_FETCH,
        ST_EXEC
    } state_t;

    typedef enum logic [1:0] {
        OPND_ZERO,
        OPND_A,
        OPND_B,
        OPND_IN
    } opnd_sel_t;

    typedef enum logic [2:0] {
        DEST_NONE,
        DEST_A,
        DEST_B,
        DEST_OUT,
        DEST_PC
    } dest_sel_t;

endpackage

// File: rtl/td4_decode.sv
// Combinational opcode decoder: maps the instruction's opcode field to operand
// source, destination register and jump/illegal flags.
module td4_decode
    import td4_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output opnd_sel_t       operand_sel,
    output dest_sel_t       dest_sel,
    output logic            imm_zero,
    output logic            is_jmp,
    output logic            is_jnc,
    output logic            illegal
);

    always_comb begin
        operand_sel = OPND_ZERO;
        dest_sel    = DEST_NONE;
        imm_zero    = 1'b0;
        is_jmp      = 1'b0;
        is_jnc      = 1'b0;
        illegal     = 1'b0;
        case (op)
            OP_ADD_A:  begin operand_sel = OPND_A;    dest_sel = DEST_A; end
            OP_ADD_B:  begin operand_sel = OPND_B;    dest_sel = DEST_B; end
            OP_MOV_AI: begin operand_sel = OPND_ZERO; dest_sel = DEST_A; end
            OP_MOV_BI: begin operand_sel = OPND_ZERO; dest_sel = DEST_B; end
            OP_MOV_AB: begin operand_sel = OPND_B;  dest_sel = DEST_A;   imm_zero = 1'b1; end
            OP_MOV_BA: begin operand_sel = OPND_A;  dest_sel = DEST_B;   imm_zero = 1'b1; end
            OP_IN_A:   begin operand_sel = OPND_IN; dest_sel = DEST_A;   imm_zero = 1'b1; end
            OP_IN_B:   begin operand_sel = OPND_IN; dest_sel = DEST_B;   imm_zero = 1'b1; end
            OP_OUT_B:  begin operand_sel = OPND_B;  dest_sel = DEST_OUT; imm_zero = 1'b1; end
            OP_OUT_I:  begin operand_sel = OPND_ZERO; dest_sel = DEST_OUT; end
            OP_JMP:    begin dest_sel = DEST_PC; is_jmp = 1'b1; end
            OP_JNC:    begin dest_sel = DEST_PC; is_jnc = 1'b1; end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 fetch/execute control: fetches an instruction over req/ack, decodes it,
// computes the result and drives the Im bus, the load strobes and the carry flag.
module td4_sequencer
    import td4_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           CLK,
    input  logic           CLR,
    input  logic [W-1:0]   pc_in,
    input  logic [W-1:0]   reg_a,
    input  logic [W-1:0]   reg_b,
    input  logic [W-1:0]   in_port,
    output logic [W-1:0]   rom_addr,
    output logic           rom_req,
    input  logic           rom_ack,
    input  logic [2*W-1:0] rom_data,
    output logic [W-1:0]   im_out,
    output logic           load_a_n,
    output logic           load_b_n,
    output logic           load_out_n,
    output logic           load_pc_n,
    output logic           carry,
    output logic           illegal
);

    localparam int IW = 2 * W;

    state_t          state;
    logic [IW-1:0]   ir;
    logic [OP_W-1:0] dec_op;
    opnd_sel_t       operand_sel;
    dest_sel_t       dest_sel;
    logic            imm_zero;
    logic            is_jmp;
    logic            is_jnc;
    logic            dec_illegal;
    logic [W-1:0]    imm;
    logic [W-1:0]    imm_eff;
    logic [W-1:0]    operand;
    logic [W:0]      sum;
    logic            accept;

    assign rom_addr = pc_in;

    // In FETCH the decoder looks at the incoming word so the strobes can be
    // registered on accept; in EXEC it looks at ir for operand and carry control.
    assign dec_op = (state == ST_EXEC) ? ir[IW-1 -: OP_W] : rom_data[IW-1 -: OP_W];

    td4_decode u_decode (
        .op          (dec_op),
        .operand_sel (operand_sel),
        .dest_sel    (dest_sel),
        .imm_zero    (imm_zero),
        .is_jmp      (is_jmp),
        .is_jnc      (is_jnc),
        .illegal     (dec_illegal)
    );

    assign imm     = ir[W-1:0];
    assign imm_eff = imm_zero ? '0 : imm;

    always_comb begin
        operand = '0;
        case (operand_sel)
            OPND_A:  operand = reg_a;
            OPND_B:  operand = reg_b;
            OPND_IN: operand = in_port;
            default: operand = '0;
        endcase
    end

    assign sum    = {1'b0, operand} + {1'b0, imm_eff};
    assign accept = (state == ST_FETCH) && rom_req && rom_ack;

    // load_pc_n low in EXEC only happens on a taken jump, where the target is imm.
    always_comb begin
        im_out = pc_in;
        if (state == ST_EXEC) begin
            im_out = load_pc_n ? sum[W-1:0] : imm;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state      <= ST_FETCH;
            ir         <= '0;
            carry      <= 1'b0;
            rom_req    <= 1'b0;
            illegal    <= 1'b0;
            load_a_n   <= 1'b1;
            load_b_n   <= 1'b1;
            load_out_n <= 1'b1;
            load_pc_n  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    rom_req <= 1'b1;
                    if (accept) begin
                        state      <= ST_EXEC;
                        ir         <= rom_data;
                        rom_req    <= 1'b0;
                        load_a_n   <= (dest_sel != DEST_A);
                        load_b_n   <= (dest_sel != DEST_B);
                        load_out_n <= (dest_sel != DEST_OUT);
                        load_pc_n  <= !(is_jmp || (is_jnc && !carry));
                        illegal    <= dec_illegal;
                    end
                end
                ST_EXEC: begin
                    state      <= ST_FETCH;
                    rom_req    <= 1'b1;
                    if (!dec_illegal) begin
                        carry <= sum[W];
                    end
                    load_a_n   <= 1'b1;
                    load_b_n   <= 1'b1;
                    load_out_n <= 1'b1;
                    load_pc_n  <= 1'b0;
                    illegal    <= 1'b0;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
